// File: rtl/tone_generator.sv
`default_nettype none
// ============================================================================
//  Module   : tone_generator
//  Purpose  : Square-wave speaker driver; half-period = countStart cycles,
//             retune and note-off only take effect at half-period boundaries.
//  Revision : 1.0
// ============================================================================
module tone_generator #(
   parameter int CNT_W = 14
) (
   input  logic             clk_5MHz,
   input  logic             rst,
   input  logic [CNT_W-1:0] countStart,
   input  logic             enable,
   output logic             speaker,
   output logic             busy,
   output logic             half_tick,
   output logic [CNT_W-1:0] active_count
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, active_nxt;
   logic             speaker_nxt, tick_nxt, play_req;

   always_ff @(posedge clk_5MHz or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         speaker      <= 1'b0;
         busy         <= 1'b0;
         half_tick    <= 1'b0;
         active_count <= '0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         speaker      <= speaker_nxt;
         busy         <= (state_nxt == RUN);
         half_tick    <= tick_nxt;
         active_count <= active_nxt;
      end
   end

   always_comb begin
      play_req    = enable && (countStart != '0);
      state_nxt   = state;
      cnt_nxt     = cnt;
      speaker_nxt = speaker;
      tick_nxt    = 1'b0;
      active_nxt  = active_count;

      case (state)
         IDLE: begin
            speaker_nxt = 1'b0;
            active_nxt  = '0;
            cnt_nxt     = '0;
            if (play_req) begin
               state_nxt   = RUN;
               speaker_nxt = 1'b1;
               tick_nxt    = 1'b1;
               active_nxt  = countStart;
               cnt_nxt     = countStart - ONE;
            end
         end
         RUN: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - ONE;
            end else if (play_req) begin
               // New count governs the half-period starting at this boundary.
               speaker_nxt = ~speaker;
               tick_nxt    = 1'b1;
               active_nxt  = countStart;
               cnt_nxt     = countStart - ONE;
            end else begin
               // A falling edge is only produced if we were high.
               state_nxt   = IDLE;
               speaker_nxt = 1'b0;
               tick_nxt    = speaker;
               active_nxt  = '0;
               cnt_nxt     = '0;
            end
         end
         default: begin
            state_nxt   = IDLE;
            speaker_nxt = 1'b0;
            active_nxt  = '0;
            cnt_nxt     = '0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_tone_generator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tone_generator
//  Purpose  : Self-checking bench for tone_generator against a phase model.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_tone_generator;

   logic        clk_5MHz = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic [13:0] countStart = '0;
   logic        speaker, busy, half_tick;
   logic [13:0] active_count;

   int checks   = 0;
   int failures = 0;

   // Model: tracks how long the current half-period has lasted vs. its length.
   logic        m_run, m_spk, m_tick;
   logic [13:0] m_len;
   int          m_el;

   tone_generator #(.CNT_W(14)) dut (
      .clk_5MHz    (clk_5MHz),
      .rst         (rst),
      .countStart  (countStart),
      .enable      (enable),
      .speaker     (speaker),
      .busy        (busy),
      .half_tick   (half_tick),
      .active_count(active_count)
   );

   always #100 clk_5MHz = ~clk_5MHz;

   function automatic logic [16:0] dut_vec();
      return {speaker, busy, half_tick, active_count};
   endfunction

   function automatic logic [16:0] mdl_vec();
      return {m_spk, m_run, m_tick, m_len};
   endfunction

   task automatic model_reset();
      m_run = 1'b0; m_spk = 1'b0; m_tick = 1'b0; m_len = '0; m_el = 0;
   endtask

   task automatic step(input logic e, input logic [13:0] c);
      bit req;
      enable     = e;
      countStart = c;
      req        = e && (c != 14'd0);
      @(posedge clk_5MHz);
      if (rst) begin
         model_reset();
      end else begin
         m_tick = 1'b0;
         if (!m_run) begin
            if (req) begin
               m_run = 1'b1; m_spk = 1'b1; m_tick = 1'b1; m_len = c; m_el = 1;
            end
         end else if (m_el < int'(m_len)) begin
            m_el++;
         end else if (req) begin
            m_spk = ~m_spk; m_tick = 1'b1; m_len = c; m_el = 1;
         end else begin
            m_tick = m_spk; m_spk = 1'b0; m_run = 1'b0; m_len = '0;
         end
      end
      #1;
   endtask

   task automatic go_idle();
      int n = 0;
      while (m_run && n < 20000) begin
         step(1'b0, 14'd0);
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      enable = 1'b1;
      countStart = 14'd5;
      #5 rst = 1'b1;
      #20;
      checks++;
      if (dut_vec() !== 17'd0) begin
         failures++;
         $display("FAIL reset_async got=%h exp=%h", dut_vec(), 17'd0);
      end
      repeat (3) @(posedge clk_5MHz);
      #1;
      checks++;
      if (dut_vec() !== 17'd0) begin
         failures++;
         $display("FAIL reset_held got=%h exp=%h", dut_vec(), 17'd0);
      end
      @(negedge clk_5MHz);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_steady_tone();
      int ticks[$];
      for (int i = 0; i < 19159; i++) begin
         step(1'b1, 14'd9579);
         checks++;
         if (dut_vec() !== mdl_vec()) begin
            failures++;
            $display("FAIL steady cyc=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
         end
         if (half_tick) ticks.push_back(i);
      end
      checks++;
      if (ticks.size() != 3) begin
         failures++;
         $display("FAIL steady_ticks got=%0d exp=3", ticks.size());
      end else begin
         checks++;
         if (ticks[1] - ticks[0] != 9579 || ticks[2] - ticks[1] != 9579) begin
            failures++;
            $display("FAIL steady_period got=%0d,%0d exp=9579,9579",
                     ticks[1] - ticks[0], ticks[2] - ticks[1]);
         end
      end
      go_idle();
   endtask

   task automatic test_retune();
      int ticks[$];
      int i = 0;
      logic [13:0] act_at_tick = '0;
      while (ticks.size() < 2 && i < 20000) begin
         step(1'b1, (i < 3000) ? 14'd9579 : 14'd4780);
         checks++;
         if (dut_vec() !== mdl_vec()) begin
            failures++;
            $display("FAIL retune cyc=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
         end
         if (half_tick) begin
            ticks.push_back(i);
            act_at_tick = active_count;
         end
         i++;
      end
      while (busy && i < 30000) begin
         step(1'b0, 14'd4780);
         if (half_tick) ticks.push_back(i);
         i++;
      end
      checks++;
      if (ticks.size() != 2) begin
         failures++;
         $display("FAIL retune_ticks got=%0d exp=2", ticks.size());
      end else begin
         checks++;
         if (ticks[1] - ticks[0] != 9579 || i - 1 - ticks[1] != 4780) begin
            failures++;
            $display("FAIL retune_lengths got=%0d,%0d exp=9579,4780",
                     ticks[1] - ticks[0], i - 1 - ticks[1]);
         end
         checks++;
         if (act_at_tick !== 14'd4780) begin
            failures++;
            $display("FAIL retune_active got=%0d exp=4780", act_at_tick);
         end
      end
      model_reset();
   endtask

   task automatic test_note_off_high();
      int  hi = 0;
      int  n  = 0;
      logic [16:0] fall_vec = '1;
      for (int i = 0; i < 100; i++) begin
         step(1'b1, 14'd2390);
         if (speaker) hi++;
      end
      while (busy && n < 3000) begin
         step(1'b0, 14'd2390);
         checks++;
         if (dut_vec() !== mdl_vec()) begin
            failures++;
            $display("FAIL off_high cyc=%0d got=%h exp=%h", n, dut_vec(), mdl_vec());
         end
         if (speaker) hi++;
         if (!busy) fall_vec = dut_vec();
         n++;
      end
      checks++;
      if (hi != 2390) begin
         failures++;
         $display("FAIL off_high_len got=%0d exp=2390", hi);
      end
      checks++;
      if (fall_vec !== {1'b0, 1'b0, 1'b1, 14'd0}) begin
         failures++;
         $display("FAIL off_high_fall got=%h exp=%h", fall_vec, {1'b0, 1'b0, 1'b1, 14'd0});
      end
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 14'd2390);
         checks++;
         if (dut_vec() !== 17'd0) begin
            failures++;
            $display("FAIL off_high_stay got=%h exp=0", dut_vec());
         end
      end
      model_reset();
   endtask

   task automatic test_note_off_low();
      int ticks = 0;
      int lo    = 0;
      int n     = 0;
      while (ticks < 2 && n < 2000) begin
         step(1'b1, 14'd500);
         if (half_tick) ticks++;
         if (!speaker && busy) lo++;
         n++;
      end
      repeat (200) begin
         step(1'b1, 14'd500);
         if (!speaker && busy) lo++;
      end
      n = 0;
      while (busy && n < 1000) begin
         step(1'b0, 14'd500);
         checks++;
         if (dut_vec() !== mdl_vec()) begin
            failures++;
            $display("FAIL off_low cyc=%0d got=%h exp=%h", n, dut_vec(), mdl_vec());
         end
         if (!speaker && busy) lo++;
         n++;
      end
      checks++;
      if (lo != 500) begin
         failures++;
         $display("FAIL off_low_len got=%0d exp=500", lo);
      end
      checks++;
      if (dut_vec() !== 17'd0) begin
         failures++;
         $display("FAIL off_low_idle got=%h exp=0", dut_vec());
      end
      step(1'b1, 14'd500);
      checks++;
      if ({speaker, half_tick, busy} !== 3'b111) begin
         failures++;
         $display("FAIL retrigger got=%b exp=111", {speaker, half_tick, busy});
      end
      go_idle();
   endtask

   task automatic test_boundaries();
      logic prev;
      int   hi = 0;
      int   n  = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 14'd0);
         checks++;
         if (dut_vec() !== 17'd0) begin
            failures++;
            $display("FAIL count0 got=%h exp=0", dut_vec());
         end
      end
      prev = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 14'd1);
         checks++;
         if (speaker !== ~prev || half_tick !== 1'b1 || active_count !== 14'd1) begin
            failures++;
            $display("FAIL count1 cyc=%0d got=%b%b exp=%b1", i, speaker, half_tick, ~prev);
         end
         prev = speaker;
      end
      go_idle();
      step(1'b1, 14'd16383);
      if (speaker) hi++;
      while (busy && n < 17000) begin
         step(1'b0, 14'd16383);
         checks++;
         if (dut_vec() !== mdl_vec()) begin
            failures++;
            $display("FAIL count_max cyc=%0d got=%h exp=%h", n, dut_vec(), mdl_vec());
         end
         if (speaker) hi++;
         n++;
      end
      checks++;
      if (hi != 16383) begin
         failures++;
         $display("FAIL count_max_len got=%0d exp=16383", hi);
      end
      model_reset();
   endtask

   task automatic test_async_reset();
      repeat (20) step(1'b1, 14'd50);
      #3 rst = 1'b1;
      #1;
      checks++;
      if (dut_vec() !== 17'd0) begin
         failures++;
         $display("FAIL async_reset got=%h exp=0", dut_vec());
      end
      model_reset();
      #250 rst = 1'b0;
      step(1'b1, 14'd50);
      checks++;
      if (dut_vec() !== {1'b1, 1'b1, 1'b1, 14'd50}) begin
         failures++;
         $display("FAIL async_restart got=%h exp=%h", dut_vec(), {1'b1, 1'b1, 1'b1, 14'd50});
      end
      go_idle();
   endtask

   task automatic test_random();
      logic        e;
      logic [13:0] c;
      for (int i = 0; i < 600; i++) begin
         e = ($urandom_range(0, 7) != 0);
         c = 14'($urandom_range(0, 5));
         step(e, c);
         checks++;
         if (dut_vec() !== mdl_vec()) begin
            failures++;
            $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
         end
      end
      go_idle();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_steady_tone();
      test_retune();
      test_note_off_high();
      test_note_off_low();
      test_boundaries();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tone_generator.md
Name: tone_generator

Overview:
- Consumer of the 14-bit half-period count produced by the note-to-count lookup.
- Turns that count into a glitch-free square wave on the speaker pin, clocked at 5 MHz.
- Half-period in clk_5MHz cycles equals countStart, so the full period is 2*countStart cycles (9579 gives 261 Hz).
- Count changes and note-off take effect only at half-period boundaries, so no runt pulses are ever emitted.

Parameters:
- CNT_W, 14: width of the countStart input, the internal down-counter and active_count.

Ports:
- clk_5MHz  input   1      system clock, 5 MHz.
- rst       input   1      reset; asynchronous, active-high.
- countStart input  CNT_W  requested half-period in cycles; 0 means silence.
- enable    input   1      note gate; 1 means play.
- speaker   output  1      square-wave audio output.
- busy      output  1      1 while in RUN state.
- half_tick output  1      one-cycle pulse, asserted in the cycle in which speaker has just changed.
- active_count output CNT_W  half-period currently being generated; 0 when idle.

Behaviour:
- Reset (async, no clock needed): state=IDLE, speaker=0, busy=0, half_tick=0, active_count=0, cnt=0.
- All outputs are registered. busy is 1 exactly when state is RUN.
- Define play_req = enable && (countStart != 0), sampled at each rising edge.
- IDLE state:
  - speaker is held at 0.
  - If play_req at edge N: after edge N, speaker=1, half_tick=1, active_count=countStart, cnt=countStart-1, state=RUN.
  - Otherwise the block stays in IDLE with all outputs 0.
  - Latency from enable to the speaker rising edge is therefore one edge.
- RUN state, cnt != 0:
  - cnt decrements by 1 each cycle; speaker holds; half_tick=0.
  - countStart and enable changes are ignored mid half-period.
- RUN state, cnt == 0 (boundary):
  - If play_req: toggle speaker, half_tick=1, active_count=countStart (resampled), cnt=countStart-1, stay in RUN. The new count applies to the half-period that starts here.
  - If !play_req and speaker==1: speaker goes to 0, half_tick=1, active_count=0, state=IDLE.
  - If !play_req and speaker==0: speaker stays 0, half_tick=0, active_count=0, state=IDLE.
- Each half-period is exactly the count loaded at its start. Neither the high phase nor the low phase is ever truncated.
- The output always ends low.
- Re-trigger: after returning to IDLE, play_req is evaluated again at the next edge. Minimum gap is 1 cycle at speaker=0.
- countStart=1: boundary occurs every cycle, giving a 2.5 MHz toggle. This is legal.
- cnt arithmetic is unsigned CNT_W bits and never underflows, because a reload only happens at cnt==0.
- countStart=16383 (the maximum) must work without overflow.
- Reset asserted mid-RUN: outputs clear immediately. Once reset is released, operation restarts from IDLE.

Test Plan:
- Steady tone: rst pulse, countStart=9579, enable=1 held. Required: speaker high for 9579 cycles, low for 9579, period 19158. half_tick at every transition. busy=1. active_count=9579.
- Retune mid-phase: in the high phase at 3000 cycles in, change countStart from 9579 to 4780. Required: high lasts the full 9579 cycles, then low lasts 4780. active_count changes to 4780 at that boundary.
- Note-off in high phase: drop enable 100 cycles into a high phase with countStart=2390. Required: high completes 2390 cycles, then speaker=0 with half_tick pulse. busy=0 and active_count=0 on the same edge; output stays low thereafter.
- Note-off in low phase: drop enable mid low phase. Required: low phase completes its full count, then IDLE with no half_tick. Re-asserting enable gives speaker=1 one edge later.
- Boundary counts: enable=1 with countStart=0 means the block stays in IDLE with speaker=0. countStart=1 means speaker toggles every cycle. countStart=16383 gives half-period 16383 exactly.
- Async reset: assert rst mid high phase between clock edges. Required: speaker, busy, half_tick and active_count all go to 0 before the next edge. After release with enable=1, the tone restarts one edge later.
